// File: rtl/disp_sched_if.sv
// disp_sched_if: valid/ready handshake bundle for the two display requesters.
//   a_valid/a_data/a_ready : requester A (knapsack best value), 14-bit word
//   b_valid/b_data/b_ready : requester B (total weight), 14-bit word
// master = requester side, slave = disp_sched side.
interface disp_sched_if;
  localparam int unsigned DATA_W = 14;

  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/disp_sched.sv
// disp_sched: shares a 4-digit seven-segment display between two requesters.
// Holds the last word from each requester, shows one page at a time, converts
// the shown word (clamped to 9999) to BCD with a sequential double-dabble
// engine, and commits digits/blank atomically when the conversion finishes.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : disp_sched_if.slave, A/B valid/data/ready handshakes
//   page_sel    : manual page select (manual paging only)
//   digits      : 4 BCD digits, digit 0 in [3:0]
//   blank       : leading-zero blank mask, blank[0] always 0
//   scan_tick   : one-cycle strobe every SCAN_DIV cycles for the scan driver
//   page        : 0 = A shown, 1 = B shown
//   busy        : conversion in progress
//
// Build option: define DISP_PAGE_AUTO_EN to toggle the page automatically
// every SCAN_DIV*PAGE_TICKS cycles (page_sel is then ignored).
module disp_sched #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned PAGE_TICKS = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  disp_sched_if.slave        bus,
  input  logic               page_sel,
  output logic [15:0]        digits,
  output logic [3:0]         blank,
  output logic               scan_tick,
  output logic               page,
  output logic               busy
);

  localparam int unsigned DATA_W = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DATA_W-1:0] MAX_VAL  = DATA_W'(9999);
  localparam logic [CNT_W-1:0]  LAST_IT  = CNT_W'(DATA_W - 1);
  localparam logic [SCAN_W-1:0] SCAN_TOP = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               src_q, src_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  opnd_q, opnd_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [DATA_W-1:0]  reg_a_q, reg_a_d;
  logic [DATA_W-1:0]  reg_b_q, reg_b_d;
  logic               conv_req_q, conv_req_d;
  logic               page_q, page_d;
  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic [3:0]         blank_q, blank_d;
  logic               scan_tick_q, scan_tick_d;
  logic               busy_q, busy_d;
  logic               a_ready_q, a_ready_d;
  logic               b_ready_q, b_ready_d;

  logic               a_fire, b_fire;
  logic               page_chg;
  logic               req_now;
  logic [DATA_W-1:0]  src_val;
  logic [BCD_W-1:0]   bcd_adj;

  // Add 3 to every nibble >= 5 ahead of the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < 4; k++) begin
      if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Blank a digit when it and every higher digit are zero; digit 0 always shows.
  function automatic logic [3:0] blank_of(input logic [BCD_W-1:0] d);
    logic [3:0] m;
    m[0] = 1'b0;
    m[3] = (d[15:12] == 4'd0);
    m[2] = m[3] && (d[11:8] == 4'd0);
    m[1] = m[2] && (d[7:4]  == 4'd0);
    return m;
  endfunction

  // Handshakes and shadow registers.
  always_comb begin
    a_fire  = bus.a_valid && a_ready_q;
    b_fire  = bus.b_valid && b_ready_q;
    reg_a_d = a_fire ? bus.a_data : reg_a_q;
    reg_b_d = b_fire ? bus.b_data : reg_b_q;
  end

  // Scan divider: tick is registered so it is high while the count sits at the top.
  always_comb begin
    scan_d      = (scan_q == SCAN_TOP) ? '0 : scan_q + SCAN_W'(1);
    scan_tick_d = (scan_d == SCAN_TOP);
  end

`ifdef DISP_PAGE_AUTO_EN
  localparam int unsigned PAGE_W = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
  localparam logic [PAGE_W-1:0] PAGE_TOP = PAGE_W'(PAGE_TICKS - 1);

  logic [PAGE_W-1:0] page_cnt_q, page_cnt_d;
  logic              unused_page_sel;

  assign unused_page_sel = page_sel;

  // Automatic paging: count scan ticks, toggle the page on the wrap.
  always_comb begin
    page_cnt_d = page_cnt_q;
    page_d     = page_q;
    page_chg   = 1'b0;
    if (scan_q == SCAN_TOP) begin
      if (page_cnt_q == PAGE_TOP) begin
        page_cnt_d = '0;
        page_d     = ~page_q;
        page_chg   = 1'b1;
      end else begin
        page_cnt_d = page_cnt_q + PAGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) page_cnt_q <= '0;
    else        page_cnt_q <= page_cnt_d;
  end
`else
  // Manual paging: page follows page_sel one cycle late.
  always_comb begin
    page_d   = page_sel;
    page_chg = (page_sel != page_q);
  end
`endif

  // A write to the shown register or a page change asks for a conversion.
  assign req_now = page_chg || (a_fire && !page_q) || (b_fire && page_q);

  // Operand source sees same-cycle writes so nothing accepted at the IDLE edge is lost.
  always_comb begin
    src_val = page_d ? reg_b_d : reg_a_d;
    bcd_adj = dd_adjust(bcd_q);
  end

  // Conversion FSM next-state and output logic.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    bcd_d      = bcd_q;
    digits_d   = digits_q;
    blank_d    = blank_q;
    conv_req_d = conv_req_q || req_now;

    unique case (state_q)
      ST_IDLE: begin
        if (conv_req_q || req_now) begin
          src_d      = page_d;
          opnd_d     = (src_val > MAX_VAL) ? MAX_VAL : src_val;
          bcd_d      = '0;
          cnt_d      = '0;
          conv_req_d = 1'b0;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        bcd_d  = {bcd_adj[BCD_W-2:0], opnd_q[DATA_W-1]};
        opnd_d = {opnd_q[DATA_W-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT) state_d = ST_DONE;
      end
      ST_DONE: begin
        digits_d = bcd_q;
        blank_d  = blank_of(bcd_q);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d    = (state_d != ST_IDLE);
    a_ready_d = !((state_d != ST_IDLE) && !src_d);
    b_ready_d = !((state_d != ST_IDLE) &&  src_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      src_q       <= 1'b0;
      cnt_q       <= '0;
      opnd_q      <= '0;
      bcd_q       <= '0;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      conv_req_q  <= 1'b0;
      page_q      <= 1'b0;
      scan_q      <= '0;
      digits_q    <= '0;
      blank_q     <= 4'b1110;
      scan_tick_q <= 1'b0;
      busy_q      <= 1'b0;
      a_ready_q   <= 1'b1;
      b_ready_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      opnd_q      <= opnd_d;
      bcd_q       <= bcd_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      conv_req_q  <= conv_req_d;
      page_q      <= page_d;
      scan_q      <= scan_d;
      digits_q    <= digits_d;
      blank_q     <= blank_d;
      scan_tick_q <= scan_tick_d;
      busy_q      <= busy_d;
      a_ready_q   <= a_ready_d;
      b_ready_q   <= b_ready_d;
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign scan_tick   = scan_tick_q;
  assign page        = page_q;
  assign busy        = busy_q;
  assign bus.a_ready = a_ready_q;
  assign bus.b_ready = b_ready_q;

endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched: directed bench for disp_sched (manual paging build).
module tb_disp_sched;

  localparam int unsigned SCAN_DIV   = 8;
  localparam int unsigned PAGE_TICKS = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        page_sel = 1'b0;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        scan_tick;
  logic        page;
  logic        busy;
  int          cyc      = 0;
  int          checks   = 0;
  int          errors   = 0;

  disp_sched_if bus_if ();

  disp_sched #(
    .SCAN_DIV   (SCAN_DIV),
    .PAGE_TICKS (PAGE_TICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .page_sel  (page_sel),
    .digits    (digits),
    .blank     (blank),
    .scan_tick (scan_tick),
    .page      (page),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        src;
    logic [13:0] val;
    logic [15:0] exp_dig;
    logic [3:0]  exp_blank;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (!busy && bus_if.a_ready && bus_if.b_ready) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  // One-cycle transfer in cycle N; returns just after the N/N+1 edge.
  task automatic xfer(input logic src, input logic [13:0] val);
    @(negedge clk);
    if (src) begin bus_if.b_valid = 1'b1; bus_if.b_data = val; end
    else     begin bus_if.a_valid = 1'b1; bus_if.a_data = val; end
    @(posedge clk);
    #1;
    bus_if.a_valid = 1'b0;
    bus_if.b_valid = 1'b0;
  endtask

  task automatic measure_scan(input string tag);
    int t1, t2;
    logic got;
    t1 = 0; t2 = 0;
    got = 1'b0;
    for (int k = 0; k < 3*SCAN_DIV && !got; k++) begin
      @(negedge clk);
      if (scan_tick) begin got = 1'b1; t1 = cyc; end
    end
    chk({tag, "_tick_seen"}, 32'(got), 32'(1));
    @(negedge clk);
    chk({tag, "_tick_width"}, 32'(scan_tick), 32'(0));
    got = 1'b0;
    for (int k = 0; k < 3*SCAN_DIV && !got; k++) begin
      if (scan_tick) begin got = 1'b1; t2 = cyc; end
      else @(negedge clk);
    end
    chk({tag, "_tick_period"}, 32'(t2 - t1), 32'(SCAN_DIV));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] last_a, last_b, prev;
    logic        acc;
    int          acc_at;

    vecs[0]  = '{1'b0, 14'd1234,  16'h1234, 4'b0000};
    vecs[1]  = '{1'b0, 14'd12000, 16'h9999, 4'b0000};
    vecs[2]  = '{1'b0, 14'd7,     16'h0007, 4'b1110};
    vecs[3]  = '{1'b0, 14'd0,     16'h0000, 4'b1110};
    vecs[4]  = '{1'b0, 14'd9999,  16'h9999, 4'b0000};
    vecs[5]  = '{1'b0, 14'd10000, 16'h9999, 4'b0000};
    vecs[6]  = '{1'b0, 14'd16383, 16'h9999, 4'b0000};
    vecs[7]  = '{1'b1, 14'd56,    16'h0056, 4'b1100};
    vecs[8]  = '{1'b1, 14'd305,   16'h0305, 4'b1000};
    vecs[9]  = '{1'b1, 14'd4000,  16'h4000, 4'b0000};
    vecs[10] = '{1'b0, 14'd90,    16'h0090, 4'b1100};

    bus_if.a_valid = 1'b0; bus_if.a_data = '0;
    bus_if.b_valid = 1'b0; bus_if.b_data = '0;

    // Reset state.
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("rst_digits", 32'(digits), 32'h0000);
    chk("rst_blank",  32'(blank),  32'(4'b1110));
    chk("rst_page",   32'(page),   32'(0));
    chk("rst_busy",   32'(busy),   32'(0));
    chk("rst_a_ready", 32'(bus_if.a_ready), 32'(1));
    chk("rst_b_ready", 32'(bus_if.b_ready), 32'(1));
    measure_scan("idle");

    // Table-driven conversions.
    last_a = 16'h0000;
    last_b = 16'h0000;
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].src != page_sel) begin
        page_sel = vecs[i].src;
        step(2);
        wait_idle();
        chk($sformatf("v%0d_page", i), 32'(page), 32'(vecs[i].src));
        chk($sformatf("v%0d_page_digits", i), 32'(digits),
            32'(vecs[i].src ? last_b : last_a));
      end
      wait_idle();
      prev = vecs[i].src ? last_b : last_a;
      xfer(vecs[i].src, vecs[i].val);
      step(1);
      chk($sformatf("v%0d_busy_n1", i), 32'(busy), 32'(1));
      chk($sformatf("v%0d_srcrdy_n1", i),
          32'(vecs[i].src ? bus_if.b_ready : bus_if.a_ready), 32'(0));
      chk($sformatf("v%0d_othrdy_n1", i),
          32'(vecs[i].src ? bus_if.a_ready : bus_if.b_ready), 32'(1));
      step(14);
      chk($sformatf("v%0d_busy_n15", i), 32'(busy), 32'(1));
      chk($sformatf("v%0d_digits_n15", i), 32'(digits), 32'(prev));
      step(1);
      chk($sformatf("v%0d_busy_n16", i), 32'(busy), 32'(0));
      chk($sformatf("v%0d_srcrdy_n16", i),
          32'(vecs[i].src ? bus_if.b_ready : bus_if.a_ready), 32'(1));
      chk($sformatf("v%0d_digits", i), 32'(digits), 32'(vecs[i].exp_dig));
      chk($sformatf("v%0d_blank", i),  32'(blank),  32'(vecs[i].exp_blank));
      if (vecs[i].src) last_b = vecs[i].exp_dig;
      else             last_a = vecs[i].exp_dig;
    end

    // B writes while A converts; then switch page to B.
    wait_idle();
    xfer(1'b0, 14'd1234);
    step(3);
    chk("bdur_b_ready", 32'(bus_if.b_ready), 32'(1));
    bus_if.b_valid = 1'b1; bus_if.b_data = 14'd56;
    @(posedge clk); #1;
    bus_if.b_valid = 1'b0;
    step(13);
    chk("bdur_digits_a", 32'(digits), 32'h1234);
    chk("bdur_busy_n16", 32'(busy), 32'(0));
    step(1);
    chk("bdur_no_extra", 32'(busy), 32'(0));
    page_sel = 1'b1;
    step(1);
    chk("pg_busy_m1", 32'(busy), 32'(1));
    chk("pg_page_m1", 32'(page), 32'(1));
    step(14);
    chk("pg_digits_m15", 32'(digits), 32'h1234);
    step(1);
    chk("pg_digits_m16", 32'(digits), 32'h0056);
    chk("pg_blank_m16",  32'(blank),  32'(4'b1100));
    measure_scan("busy");

    // Page change coinciding with DONE.
    wait_idle();
    xfer(1'b1, 14'd777);
    step(15);
    page_sel = 1'b0;
    step(1);
    chk("done_pg_digits_old", 32'(digits), 32'h0777);
    chk("done_pg_blank_old",  32'(blank),  32'(4'b1000));
    chk("done_pg_busy_n16",   32'(busy),   32'(0));
    step(1);
    chk("done_pg_busy_n17",   32'(busy),   32'(1));
    step(14);
    chk("done_pg_digits_n31", 32'(digits), 32'h0777);
    step(1);
    chk("done_pg_digits_new", 32'(digits), 32'h1234);
    chk("done_pg_page",       32'(page),   32'(0));

    // Second A write held off by a_ready during conversion.
    wait_idle();
    xfer(1'b0, 14'd111);
    step(5);
    bus_if.a_valid = 1'b1; bus_if.a_data = 14'd2222;
    acc = 1'b0; acc_at = 0;
    for (int k = 5; k < 40 && !acc; k++) begin
      if (bus_if.a_ready) begin acc = 1'b1; acc_at = k; end
      else step(1);
    end
    chk("hold_accept_cycle", 32'(acc_at), 32'(16));
    chk("hold_first_digits", 32'(digits), 32'h0111);
    chk("hold_first_blank",  32'(blank),  32'(4'b1000));
    @(posedge clk); #1;
    bus_if.a_valid = 1'b0;
    if (acc) begin
      step(15);
      chk("hold_digits_t15", 32'(digits), 32'h0111);
      step(1);
      chk("hold_digits_final", 32'(digits), 32'h2222);
      chk("hold_blank_final",  32'(blank),  32'(4'b0000));
      for (int k = 0; k < 4; k++) begin
        step(1);
        chk($sformatf("hold_no_extra_%0d", k), 32'(busy), 32'(0));
      end
    end

    // Reset in the middle of a conversion.
    wait_idle();
    xfer(1'b0, 14'd4321);
    step(5);
    rst_n = 1'b0;
    #1;
    chk("mrst_digits",  32'(digits), 32'h0000);
    chk("mrst_blank",   32'(blank),  32'(4'b1110));
    chk("mrst_busy",    32'(busy),   32'(0));
    chk("mrst_a_ready", 32'(bus_if.a_ready), 32'(1));
    chk("mrst_b_ready", 32'(bus_if.b_ready), 32'(1));
    chk("mrst_page",    32'(page),   32'(0));
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("mrst_stays_idle", 32'(busy), 32'(0));
    xfer(1'b0, 14'd8765);
    step(16);
    chk("mrst_digits_new", 32'(digits), 32'h8765);
    chk("mrst_blank_new",  32'(blank),  32'(4'b0000));
    page_sel = 1'b1;
    step(2);
    wait_idle();
    chk("mrst_regb_digits", 32'(digits), 32'h0000);
    chk("mrst_regb_blank",  32'(blank),  32'(4'b1110));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
